// File: rtl/some_logic.sv
// Two-input registered logic unit: per-input synchronizer + deglitch filter,
// runtime-selected Boolean function, edge pulses and saturating high-time counter.

module some_logic_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic f_o
);
  localparam logic [3:0] FL_LAST = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             cnt_q;
  logic                   f_q;
  logic                   s;

  assign s   = sync_q[SYNC_STAGES-1];
  assign f_o = f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) sync_q[i] <= sync_q[i-1];
      sync_q[0] <= in_i;
      // f only moves once s has disagreed with it for FILT_LEN consecutive cycles
      if (s == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FL_LAST) begin
        f_q   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end
endmodule

module some_logic #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic [2:0]       op,
  input  logic             clr_count,
  output logic             c,
  output logic             c_rise,
  output logic             c_fall,
  output logic [CNT_W-1:0] hi_count
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] in_vec;
  logic [NUM_LANES-1:0] f_vec;
  logic                 fa, fb;
  logic                 c_d, c_q, cd_q;
  logic [CNT_W-1:0]     hi_q;

  assign in_vec = {b, a};

  some_logic_lane #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .in_i (in_vec),
    .f_o  (f_vec)
  );

  assign fa = f_vec[0];
  assign fb = f_vec[1];

  always_comb begin
    c_d = fa;
    case (op)
      3'b000:  c_d = fa & fb;
      3'b001:  c_d = fa | fb;
      3'b010:  c_d = fa ^ fb;
      3'b011:  c_d = ~(fa & fb);
      3'b100:  c_d = ~(fa | fb);
      3'b101:  c_d = ~(fa ^ fb);
      3'b110:  c_d = fa & ~fb;
      default: c_d = fa;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= 1'b0;
      cd_q <= 1'b0;
      hi_q <= '0;
    end else begin
      c_q  <= c_d;
      cd_q <= c_q;
      if (clr_count)
        hi_q <= '0;
      else if (c_q && (hi_q != {CNT_W{1'b1}}))
        hi_q <= hi_q + 1'b1;
    end
  end

  // Pulses decode two flops only, so they cannot glitch
  assign c        = c_q;
  assign c_rise   = c_q & ~cd_q;
  assign c_fall   = ~c_q & cd_q;
  assign hi_count = hi_q;
endmodule

// File: tb/tb_some_logic.sv
// Bench for some_logic: three parameterizations share stimulus and are checked
// every cycle against a windowed reference model, plus directed sequences.

module tb_some_logic;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a = 1'b0, b = 1'b0, clr = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [2:0]  c_o, cr_o, cf_o;
  logic [15:0] hc0, hc1;
  logic [3:0]  hc2;

  int errors = 0;
  int checks = 0;

  localparam int SY [3] = '{2, 2, 1};
  localparam int FL [3] = '{1, 3, 2};
  localparam int CW [3] = '{16, 16, 4};
  localparam int HMAX = 8192;

  always #5 clk = ~clk;

  some_logic u0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .clr_count(clr),
    .c(c_o[0]), .c_rise(cr_o[0]), .c_fall(cf_o[0]), .hi_count(hc0));
  some_logic #(.SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .clr_count(clr),
    .c(c_o[1]), .c_rise(cr_o[1]), .c_fall(cf_o[1]), .hi_count(hc1));
  some_logic #(.SYNC_STAGES(1), .FILT_LEN(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .clr_count(clr),
    .c(c_o[2]), .c_rise(cr_o[2]), .c_fall(cf_o[2]), .hi_count(hc2));

  // Reference model: input history since reset plus per-instance state
  bit ah [HMAX];
  bit bh [HMAX];
  int k;
  bit m_fa [3], m_fb [3], m_c [3], m_cq [3];
  int m_hi [3];

  function automatic bit fn(input logic [2:0] o, input bit x, input bit y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return !(x & y);
      3'd4: return !(x | y);
      3'd5: return !(x ^ y);
      3'd6: return x & !y;
      default: return x;
    endcase
  endfunction

  // Synced value seen by instance i after edge t (0 before any sample)
  function automatic bit s_of(input int i, input bit use_b, input int t);
    int idx;
    idx = t - SY[i] + 1;
    if (idx < 0) return 1'b0;
    return use_b ? bh[idx] : ah[idx];
  endfunction

  // Filter flips when the last FL synced samples all disagree with it
  function automatic bit f_next(input int i, input bit use_b, input bit f_old);
    bit all_diff;
    all_diff = 1'b1;
    for (int j = 0; j < FL[i]; j++)
      if (s_of(i, use_b, k - 1 - j) == f_old) all_diff = 1'b0;
    return all_diff ? !f_old : f_old;
  endfunction

  task automatic model_clear();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      m_fa[i] = 0; m_fb[i] = 0; m_c[i] = 0; m_cq[i] = 0; m_hi[i] = 0;
    end
  endtask

  task automatic model_adv();
    bit nc, nfa, nfb;
    int nhi;
    ah[k] = a;
    bh[k] = b;
    for (int i = 0; i < 3; i++) begin
      nc  = fn(op, m_fa[i], m_fb[i]);
      nfa = f_next(i, 1'b0, m_fa[i]);
      nfb = f_next(i, 1'b1, m_fb[i]);
      if (clr) nhi = 0;
      else if (m_c[i] && m_hi[i] < (1 << CW[i]) - 1) nhi = m_hi[i] + 1;
      else nhi = m_hi[i];
      m_cq[i] = m_c[i];
      m_c[i]  = nc;
      m_fa[i] = nfa;
      m_fb[i] = nfb;
      m_hi[i] = nhi;
    end
    if (k < HMAX - 1) k++;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  function automatic int hi_of(input int i);
    case (i)
      0: return int'(hc0);
      1: return int'(hc1);
      default: return int'(hc2);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.c", i),        int'(c_o[i]),  int'(m_c[i]));
      chk($sformatf("u%0d.c_rise", i),   int'(cr_o[i]), int'(m_c[i] & !m_cq[i]));
      chk($sformatf("u%0d.c_fall", i),   int'(cf_o[i]), int'(!m_c[i] & m_cq[i]));
      chk($sformatf("u%0d.hi_count", i), hi_of(i),      m_hi[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_clear();
    else model_adv();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       exp_c;
  } vec_t;

  vec_t       vec [32];
  logic [3:0] tt [8];
  int         hcnt;

  initial begin
    // truth table indexed by {a,b}
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] row;
      logic [1:0] ab;
      row = tt[i / 4];
      ab  = 2'(i % 4);
      vec[i] = '{op: 3'(i / 4), a: ab[1], b: ab[0], exp_c: row[ab]};
    end
    model_clear();

    // Reset held with NAND and inputs high
    rst_n = 1'b0; a = 1'b1; b = 1'b1; op = 3'b011;
    #1;
    chk("rst.c", int'(c_o[0]), 0);
    chk("rst.hi", int'(hc0), 0);
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("post_rst.c", int'(c_o[0]), 0);
    chk("post_rst.rise", int'(cr_o[0]), 0);
    chk("post_rst.fall", int'(cf_o[0]), 0);

    // Latency and edge pulses on the default instance
    op = 3'b000; a = 1'b0; b = 1'b0; clr = 1'b1;
    for (int i = 0; i < 8; i++) step();
    a = 1'b1; b = 1'b1; clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("lat.c_early", int'(c_o[0]), 0);
    step();
    chk("lat.c", int'(c_o[0]), 1);
    chk("lat.rise", int'(cr_o[0]), 1);
    chk("lat.hi0", int'(hc0), 0);
    step();
    chk("lat.rise_once", int'(cr_o[0]), 0);
    chk("lat.hi1", int'(hc0), 1);
    b = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("fall.c_early", int'(c_o[0]), 1);
    step();
    chk("fall.c", int'(c_o[0]), 0);
    chk("fall.pulse", int'(cf_o[0]), 1);
    step();
    chk("fall.once", int'(cf_o[0]), 0);

    // Function table sweep
    foreach (vec[i]) begin
      op = vec[i].op; a = vec[i].a; b = vec[i].b;
      for (int j = 0; j < 6; j++) step();
      chk($sformatf("tbl.op%0d.a%0d.b%0d", vec[i].op, vec[i].a, vec[i].b),
          int'(c_o[0]), int'(vec[i].exp_c));
    end

    // Pulse filtering on the FILT_LEN=3 instance
    op = 3'b000; a = 1'b0; b = 1'b1;
    for (int i = 0; i < 10; i++) step();
    a = 1'b1;
    step(); step();
    a = 1'b0;
    hcnt = 0;
    for (int i = 0; i < 14; i++) begin step(); hcnt += int'(c_o[1]); end
    chk("filt.short_pulse", hcnt, 0);
    a = 1'b1;
    step(); step(); step();
    a = 1'b0;
    hcnt = 0;
    for (int i = 0; i < 14; i++) begin step(); hcnt += int'(c_o[1]); end
    chk("filt.long_pulse", hcnt, 3);

    // Saturation on the CNT_W=4 instance
    a = 1'b1; b = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 24; i++) step();
    chk("sat.hi", int'(hc2), 15);
    clr = 1'b1;
    step();
    chk("sat.clr", int'(hc2), 0);
    clr = 1'b0;
    step();
    chk("sat.resume1", int'(hc2), 1);
    step();
    chk("sat.resume2", int'(hc2), 2);

    // Random traffic with one asynchronous mid-run reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      if ($urandom_range(0, 15) == 0) op = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 31) == 0);
      if (n == 200) begin
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
